// File: rtl/tt_gpio_irq_ctrl.sv
// GPIO block: output/enable registers, synchronized pad inputs and per-channel
// edge/level interrupt capture with write-1-to-clear pending bits.

module tt_gpio_irq_lane #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    input  logic en,
    input  logic lvl,
    input  logic pol,
    input  logic clr,
    output logic s,
    output logic pend
);
    logic [SYNC_STAGES-1:0] sync;
    logic                   d;
    logic                   evt;

    assign s = sync[SYNC_STAGES-1];

    always_comb begin
        evt = 1'b0;
        if (lvl) evt = s ^ pol;
        else     evt = pol ? (~s & d) : (s & ~d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            d    <= 1'b0;
            pend <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pin};
            d    <= s;
            // set has priority over a same-cycle clear
            pend <= (pend & ~clr) | (evt & en);
        end
    end
endmodule

module tt_gpio_irq_ctrl #(
    parameter int NCH         = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           we,
    input  logic           re,
    input  logic [2:0]     addr,
    input  logic [NCH-1:0] wdata,
    output logic [NCH-1:0] rdata,
    output logic           rvalid,
    input  logic [NCH-1:0] pin_in,
    output logic [NCH-1:0] pin_out,
    output logic [NCH-1:0] pin_oe,
    output logic           irq
);
    localparam logic [2:0] A_OUT  = 3'd0;
    localparam logic [2:0] A_OE   = 3'd1;
    localparam logic [2:0] A_IN   = 3'd2;
    localparam logic [2:0] A_EN   = 3'd3;
    localparam logic [2:0] A_LVL  = 3'd4;
    localparam logic [2:0] A_POL  = 3'd5;
    localparam logic [2:0] A_PEND = 3'd6;
    localparam logic [2:0] A_TOG  = 3'd7;

    logic [NCH-1:0] out_q, oe_q, en_q, lvl_q, pol_q;
    logic [NCH-1:0] sync_s, pend, clr, rd_mux;

    assign clr = (we && addr == A_PEND) ? wdata : '0;

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        tt_gpio_irq_lane #(.SYNC_STAGES(SYNC_STAGES)) u_lane (
            .clk  (clk),
            .rst_n(rst_n),
            .pin  (pin_in[i]),
            .en   (en_q[i]),
            .lvl  (lvl_q[i]),
            .pol  (pol_q[i]),
            .clr  (clr[i]),
            .s    (sync_s[i]),
            .pend (pend[i])
        );
    end

    always_comb begin
        rd_mux = '0;
        case (addr)
            A_OUT:   rd_mux = out_q;
            A_OE:    rd_mux = oe_q;
            A_IN:    rd_mux = sync_s;
            A_EN:    rd_mux = en_q;
            A_LVL:   rd_mux = lvl_q;
            A_POL:   rd_mux = pol_q;
            A_PEND:  rd_mux = pend;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            oe_q   <= '0;
            en_q   <= '0;
            lvl_q  <= '0;
            pol_q  <= '0;
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            if (we) begin
                case (addr)
                    A_OUT:   out_q <= wdata;
                    A_OE:    oe_q  <= wdata;
                    A_EN:    en_q  <= wdata;
                    A_LVL:   lvl_q <= wdata;
                    A_POL:   pol_q <= wdata;
                    A_TOG:   out_q <= out_q ^ wdata;
                    default: ;
                endcase
            end
            // the mux sees pre-write state, so a same-cycle read returns the old value
            rvalid <= re;
            if (re) rdata <= rd_mux;
        end
    end

    assign pin_out = out_q;
    assign pin_oe  = oe_q;
    assign irq     = |(pend & en_q);
endmodule

// File: tb/tb_tt_gpio_irq_ctrl.sv
// Self-checking bench for tt_gpio_irq_ctrl: directed scenarios plus a randomized
// pass against a set-level model of the interrupt rules.

module tb_tt_gpio_irq_ctrl;
    logic       clk, rst_n, we, re, rvalid, irq;
    logic [2:0] addr;
    logic [7:0] wdata, rdata, pin_in, pin_out, pin_oe;
    int errs, checks;

    tt_gpio_irq_ctrl #(.NCH(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .re(re), .addr(addr), .wdata(wdata),
        .rdata(rdata), .rvalid(rvalid), .pin_in(pin_in), .pin_out(pin_out),
        .pin_oe(pin_oe), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired errors=%0d of %0d checks", errs, checks);
        $fatal(1, "timeout");
    end

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk); we = 1'b1; addr = a; wdata = d;
        @(negedge clk); we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] d, output logic v);
        @(negedge clk); re = 1'b1; addr = a;
        @(negedge clk); re = 1'b0; d = rdata; v = rvalid;
    endtask

    task automatic test_reset;
        checks++;
        if ({pin_out, pin_oe, rdata, rvalid, irq} !== 26'd0) begin
            errs++;
            $display("FAIL reset_outputs got out=%h oe=%h rd=%h rv=%b irq=%b exp all 0",
                     pin_out, pin_oe, rdata, rvalid, irq);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_out_toggle;
        logic [7:0] d; logic v;
        wr(0, 8'hA5); wr(1, 8'h0F); wr(7, 8'hFF);
        checks++;
        if (pin_out !== 8'h5A || pin_oe !== 8'h0F) begin
            errs++; $display("FAIL toggle_pins got out=%h oe=%h exp 5a 0f", pin_out, pin_oe);
        end
        rd(0, d, v);
        checks++;
        if (d !== 8'h5A || v !== 1'b1) begin
            errs++; $display("FAIL read_out got %h rv=%b exp 5a rv=1", d, v);
        end
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b0 || rdata !== 8'h5A) begin
            errs++; $display("FAIL rvalid_pulse got rv=%b rd=%h exp rv=0 rd=5a", rvalid, rdata);
        end
        wr(2, 8'hFF);
        rd(2, d, v);
        checks++;
        if (d !== 8'h00) begin errs++; $display("FAIL in_readonly got %h exp 00", d); end
        rd(7, d, v);
        checks++;
        if (d !== 8'h00) begin errs++; $display("FAIL toggle_reads0 got %h exp 00", d); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk); re = 1'b1; addr = 3'd0;
        @(negedge clk); addr = 3'd1;
        checks++;
        if (rvalid !== 1'b1 || rdata !== 8'h5A) begin
            errs++; $display("FAIL b2b_first got rv=%b rd=%h exp 1 5a", rvalid, rdata);
        end
        @(negedge clk); re = 1'b0;
        checks++;
        if (rvalid !== 1'b1 || rdata !== 8'h0F) begin
            errs++; $display("FAIL b2b_second got rv=%b rd=%h exp 1 0f", rvalid, rdata);
        end
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b0) begin errs++; $display("FAIL b2b_end got rv=%b exp 0", rvalid); end
    endtask

    task automatic test_edge_irq;
        logic [7:0] d; logic v;
        wr(4, 8'h00); wr(5, 8'h00); wr(3, 8'h01);
        @(negedge clk); pin_in[0] = 1'b1;
        // rising edges after the change: sample, s visible, pending set
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (irq !== (k == 3)) begin
                errs++; $display("FAIL edge_latency edge=%0d got irq=%b exp %b", k, irq, k == 3);
            end
        end
        rd(6, d, v);
        checks++;
        if (d !== 8'h01) begin errs++; $display("FAIL edge_pend got %h exp 01", d); end
        @(negedge clk); we = 1'b1; addr = 3'd6; wdata = 8'h01;
        @(negedge clk); we = 1'b0;
        checks++;
        if (irq !== 1'b0) begin errs++; $display("FAIL edge_w1c got irq=%b exp 0", irq); end
        pin_in[0] = 1'b0;
        wr(3, 8'h00);
    endtask

    task automatic test_level;
        logic [7:0] d; logic v;
        wr(4, 8'h80); wr(5, 8'h80); wr(3, 8'h80);
        repeat (2) @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin errs++; $display("FAIL level_set got irq=%b exp 1", irq); end
        @(negedge clk); we = 1'b1; addr = 3'd6; wdata = 8'h80;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); we = 1'b0;
            checks++;
            if (irq !== 1'b1) begin errs++; $display("FAIL level_hold cyc=%0d got irq=%b exp 1", k, irq); end
        end
        rd(6, d, v);
        checks++;
        if (d !== 8'h80) begin errs++; $display("FAIL level_pend got %h exp 80", d); end
        wr(3, 8'h00);
        checks++;
        if (irq !== 1'b0) begin errs++; $display("FAIL en_masks_irq got irq=%b exp 0", irq); end
        rd(6, d, v);
        checks++;
        if (d !== 8'h80) begin errs++; $display("FAIL en_clear_keeps_pend got %h exp 80", d); end
        wr(4, 8'h00); wr(5, 8'h00); wr(6, 8'hFF);
    endtask

    task automatic test_set_wins;
        logic [7:0] d; logic v;
        wr(3, 8'h04);
        @(negedge clk); pin_in[2] = 1'b1;
        @(negedge clk);
        // clear strobe lands on the same edge that records the event
        @(negedge clk); we = 1'b1; addr = 3'd6; wdata = 8'h04;
        @(negedge clk); we = 1'b0;
        rd(6, d, v);
        checks++;
        if (d !== 8'h04 || irq !== 1'b1) begin
            errs++; $display("FAIL set_wins got pend=%h irq=%b exp 04 1", d, irq);
        end
        wr(6, 8'h04);
        rd(6, d, v);
        checks++;
        if (d !== 8'h00) begin errs++; $display("FAIL set_wins_clear got %h exp 00", d); end
        wr(3, 8'h00);
        pin_in = 8'h00;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_rw_same;
        logic [7:0] d; logic v;
        wr(3, 8'h11);
        @(negedge clk); we = 1'b1; re = 1'b1; addr = 3'd3; wdata = 8'h33;
        @(negedge clk); we = 1'b0; re = 1'b0;
        checks++;
        if (rvalid !== 1'b1 || rdata !== 8'h11) begin
            errs++; $display("FAIL rw_same got rv=%b rd=%h exp 1 11", rvalid, rdata);
        end
        rd(3, d, v);
        checks++;
        if (d !== 8'h33) begin errs++; $display("FAIL rw_after got %h exp 33", d); end
        wr(3, 8'h00);
    endtask

    task automatic test_random;
        logic [7:0] d, m_out, m_oe, m_en, m_lvl, m_pol, m_pend, pins, np, lmatch, edg;
        logic v;
        m_out = 8'h5A; m_oe = 8'h0F; pins = 8'h00;
        for (int it = 0; it < 24; it++) begin
            d = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin wr(0, d); m_out = d; end
            else begin wr(7, d); m_out = m_out ^ d; end
            m_oe = 8'($urandom); wr(1, m_oe);
            m_en = 8'($urandom); m_lvl = 8'($urandom); m_pol = 8'($urandom);
            wr(3, 8'h00); wr(4, m_lvl); wr(5, m_pol); wr(3, m_en); wr(6, 8'hFF);
            m_pend = m_en & m_lvl & (m_pol ^ pins);
            np = 8'($urandom);
            @(negedge clk); pin_in = np;
            repeat (4) @(negedge clk);
            lmatch = m_pol ^ np;
            edg = (m_pol & pins & ~np) | (~m_pol & ~pins & np);
            m_pend = m_pend | (m_en & ((m_lvl & lmatch) | (~m_lvl & edg)));
            pins = np;
            checks++;
            if (pin_out !== m_out || pin_oe !== m_oe) begin
                errs++; $display("FAIL rnd_pins it=%0d got %h %h exp %h %h", it, pin_out, pin_oe, m_out, m_oe);
            end
            rd(2, d, v);
            checks++;
            if (d !== pins) begin errs++; $display("FAIL rnd_in it=%0d got %h exp %h", it, d, pins); end
            rd(6, d, v);
            checks++;
            if (d !== m_pend) begin errs++; $display("FAIL rnd_pend it=%0d got %h exp %h", it, d, m_pend); end
            checks++;
            if (irq !== |(m_pend & m_en)) begin
                errs++; $display("FAIL rnd_irq it=%0d got %b exp %b", it, irq, |(m_pend & m_en));
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] d; logic v;
        pin_in = 8'hFF;
        wr(4, 8'hFF); wr(3, 8'hFF); wr(0, 8'h3C); wr(1, 8'hC3);
        repeat (3) @(negedge clk);
        @(negedge clk); re = 1'b1; addr = 3'd0;
        @(posedge clk); #1 rst_n = 1'b0; re = 1'b0;
        #1;
        checks++;
        if ({pin_out, pin_oe, rdata, rvalid, irq} !== 26'd0) begin
            errs++; $display("FAIL reset_mid got out=%h oe=%h rd=%h rv=%b irq=%b exp all 0",
                             pin_out, pin_oe, rdata, rvalid, irq);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (5) @(negedge clk);
        rd(6, d, v);
        checks++;
        if (d !== 8'h00 || irq !== 1'b0) begin
            errs++; $display("FAIL post_reset_pend got %h irq=%b exp 00 0", d, irq);
        end
        rd(2, d, v);
        checks++;
        if (d !== 8'hFF) begin errs++; $display("FAIL post_reset_in got %h exp ff", d); end
    endtask

    initial begin
        errs = 0; checks = 0;
        rst_n = 1'b0; we = 1'b0; re = 1'b0; addr = 3'd0; wdata = 8'h00; pin_in = 8'h00;
        repeat (2) @(negedge clk);
        test_reset;
        test_out_toggle;
        test_back_to_back;
        test_edge_irq;
        test_level;
        test_set_wins;
        test_rw_same;
        test_random;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
